// File: rtl/ctrl_defs.sv
// Shared definitions for the control-bundle pipeline: bundle layout, jump codes, ALU op class.
package ctrl_defs;

    localparam int CTRL_W = 10;

    // {jump[1:0], branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
    localparam int REG_WRITE_BIT  = 0;
    localparam int ALU_SRC_BIT    = 1;
    localparam int MEM_WRITE_BIT  = 2;
    localparam int ALU_OP_LSB     = 3;
    localparam int ALU_OP_MSB     = 4;
    localparam int MEM_TO_REG_BIT = 5;
    localparam int MEM_READ_BIT   = 6;
    localparam int BRANCH_BIT     = 7;
    localparam int JUMP_LSB       = 8;
    localparam int JUMP_MSB       = 9;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_JAL  = 2'b01,
        JUMP_JALR = 2'b10,
        JUMP_RSVD = 2'b11
    } jump_e;

    localparam logic [1:0]        ALU_OP_R    = 2'b10;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection for the ID stage; with CTRL_PIPELINE_FWD_EN it also
// selects EX operand forwarding and stalls only on load-use.
module hazard_unit
    import ctrl_defs::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [1:0]        id_jump,
    input  logic              id_branch,
    input  logic              id_mem_write,
    input  logic [1:0]        id_alu_op,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
`ifdef CTRL_PIPELINE_FWD_EN
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
`else
    input  logic              ex_reg_write,
`endif
    input  logic              ex_redirect,
    output logic              stall
);

    logic rs1_used;
    logic rs2_used;
    logic ex_hit;
    logic load_use;
    logic hazard;

    always_comb begin
        rs1_used = (id_jump != JUMP_JAL);
        rs2_used = id_branch | id_mem_write | (id_alu_op == ALU_OP_R);
        ex_hit   = (ex_rd != '0) &&
                   ((rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd)));
        load_use = id_valid & ex_valid & ex_mem_read & ex_hit;
    end

`ifdef CTRL_PIPELINE_FWD_EN
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              m_v,
        input logic              m_w,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_v,
        input logic              w_w,
        input logic [REG_AW-1:0] w_rd
    );
        if (m_v && m_w && (m_rd != '0) && (m_rd == rs))
            return 2'b10;
        else if (w_v && w_w && (w_rd != '0) && (w_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        hazard = load_use;
        fwd_a  = fwd_sel(ex_rs1, mem_valid, mem_reg_write, mem_rd, wb_valid, wb_reg_write, wb_rd);
        fwd_b  = fwd_sel(ex_rs2, mem_valid, mem_reg_write, mem_rd, wb_valid, wb_reg_write, wb_rd);
    end
`else
    logic mem_hit;

    // Without forwarding every pending write in EX or MEM blocks ID; WB is covered by the
    // write-first register file.
    always_comb begin
        mem_hit = (mem_rd != '0) &&
                  ((rs1_used && (id_rs1 == mem_rd)) || (rs2_used && (id_rs2 == mem_rd)));
        hazard  = load_use |
                  (id_valid & ((ex_valid & ex_reg_write & ex_hit) |
                               (mem_valid & mem_reg_write & mem_hit)));
    end
`endif

    always_comb stall = hazard & ~ex_redirect;

endmodule

// File: rtl/ctrl_pipeline.sv
// ID->EX->MEM->WB control-bundle stage registers with bubble insertion on stall/redirect.
// Optional CTRL_PIPELINE_FWD_EN adds fwd_a/fwd_b forwarding selects.
module ctrl_pipeline #(
    parameter int REG_AW = 5,
    parameter int CTRL_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
`ifdef CTRL_PIPELINE_FWD_EN
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
`endif
    output logic              stall,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid
);

    import ctrl_defs::*;

    logic bubble;

    always_comb bubble = ex_redirect | stall | ~id_valid;

`ifdef CTRL_PIPELINE_FWD_EN
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (bubble) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_ctrl   <= '0;
            ex_rd     <= '0;
            ex_valid  <= 1'b0;
            mem_ctrl  <= '0;
            mem_rd    <= '0;
            mem_valid <= 1'b0;
            wb_ctrl   <= '0;
            wb_rd     <= '0;
            wb_valid  <= 1'b0;
        end else begin
            if (bubble) begin
                ex_ctrl  <= CTRL_BUBBLE;
                ex_rd    <= '0;
                ex_valid <= 1'b0;
            end else begin
                ex_ctrl  <= id_ctrl;
                ex_rd    <= id_rd;
                ex_valid <= 1'b1;
            end
            mem_ctrl  <= ex_ctrl;
            mem_rd    <= ex_rd;
            mem_valid <= ex_valid;
            wb_ctrl   <= mem_ctrl;
            wb_rd     <= mem_rd;
            wb_valid  <= mem_valid;
        end
    end

    hazard_unit #(
        .REG_AW(REG_AW)
    ) u_hazard (
        .id_valid      (id_valid),
        .id_jump       (id_ctrl[JUMP_MSB:JUMP_LSB]),
        .id_branch     (id_ctrl[BRANCH_BIT]),
        .id_mem_write  (id_ctrl[MEM_WRITE_BIT]),
        .id_alu_op     (id_ctrl[ALU_OP_MSB:ALU_OP_LSB]),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_ctrl[MEM_READ_BIT]),
        .ex_rd         (ex_rd),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_ctrl[REG_WRITE_BIT]),
        .mem_rd        (mem_rd),
`ifdef CTRL_PIPELINE_FWD_EN
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_ctrl[REG_WRITE_BIT]),
        .wb_rd         (wb_rd),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
`else
        .ex_reg_write  (ex_ctrl[REG_WRITE_BIT]),
`endif
        .ex_redirect   (ex_redirect),
        .stall         (stall)
    );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline (default build): directed table, async reset, random vs model.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       rstn;
    logic       id_valid;
    logic [9:0] id_ctrl;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect;
    logic       stall;
    logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_valid, mem_valid, wb_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_AW(5), .CTRL_W(10)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(stall), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid)
    );

    typedef struct {
        logic v; logic [9:0] ctrl; logic [4:0] rs1, rs2, rd; logic red;
        logic stall; logic [9:0] ex_ctrl; logic [4:0] ex_rd; logic ex_v;
        logic [4:0] mem_rd; logic [4:0] wb_rd; logic [9:0] wb_ctrl; logic wb_v;
    } vec_t;

    typedef struct { logic v; logic [9:0] ctrl; logic [4:0] rd; } stg_t;

    function automatic vec_t mk(input logic v, input logic [9:0] c, input logic [4:0] r1, r2, rd,
                                input logic red, input logic st, input logic [9:0] ec,
                                input logic [4:0] erd, input logic ev, input logic [4:0] mrd,
                                input logic [4:0] wrd, input logic [9:0] wc, input logic wv);
        vec_t t;
        t.v = v; t.ctrl = c; t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.red = red;
        t.stall = st; t.ex_ctrl = ec; t.ex_rd = erd; t.ex_v = ev;
        t.mem_rd = mrd; t.wb_rd = wrd; t.wb_ctrl = wc; t.wb_v = wv;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] r1, r2, rd,
                         input logic red);
        id_valid = v; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_redirect = red;
    endtask

    // Reference: operand-use and hazard rules expressed directly on bundle fields.
    function automatic logic reads_reg(input logic [9:0] c, input logic [4:0] r1, r2, r);
        logic u1, u2;
        u1 = (c[9:8] != 2'b01);
        u2 = c[7] | c[2] | (c[4:3] == 2'b10);
        return (r != 5'd0) && ((u1 && r1 == r) || (u2 && r2 == r));
    endfunction

    localparam logic [9:0] LW  = 10'h063;
    localparam logic [9:0] ADD = 10'h011;
    localparam logic [9:0] SW  = 10'h006;

    vec_t tbl[18];
    stg_t pipe[$];

    initial begin
        tbl[0]  = mk(1, LW,  1, 0, 5,  0, 0, LW,  5, 1, 0,  0,  10'h0, 0);
        tbl[1]  = mk(1, ADD, 5, 6, 8,  0, 1, 10'h0, 0, 0, 5, 0,  10'h0, 0);
        tbl[2]  = mk(1, ADD, 5, 6, 8,  0, 1, 10'h0, 0, 0, 0, 5,  LW,    1);
        tbl[3]  = mk(1, ADD, 5, 6, 8,  0, 0, ADD, 8, 1, 0,  0,  10'h0, 0);
        tbl[4]  = mk(1, LW,  2, 0, 0,  0, 0, LW,  0, 1, 8,  0,  10'h0, 0);
        tbl[5]  = mk(1, ADD, 0, 0, 9,  0, 0, ADD, 9, 1, 0,  8,  ADD,   1);
        tbl[6]  = mk(1, LW,  3, 0, 7,  0, 0, LW,  7, 1, 9,  0,  LW,    1);
        tbl[7]  = mk(1, SW,  4, 7, 0,  0, 1, 10'h0, 0, 0, 7, 9,  ADD,   1);
        tbl[8]  = mk(1, SW,  4, 7, 0,  1, 0, 10'h0, 0, 0, 0, 7,  LW,    1);
        tbl[9]  = mk(1, LW,  1, 0, 11, 0, 0, LW, 11, 1, 0,  0,  10'h0, 0);
        tbl[10] = mk(1, ADD, 11, 0, 12, 1, 0, 10'h0, 0, 0, 11, 0, 10'h0, 0);
        tbl[11] = mk(0, ADD, 11, 0, 13, 0, 0, 10'h0, 0, 0, 0, 11, LW,    1);
        tbl[12] = mk(1, ADD, 0, 0, 1,  0, 0, ADD, 1, 1, 0,  0,  10'h0, 0);
        tbl[13] = mk(1, ADD, 0, 0, 2,  0, 0, ADD, 2, 1, 1,  0,  10'h0, 0);
        tbl[14] = mk(1, ADD, 0, 0, 3,  0, 0, ADD, 3, 1, 2,  1,  ADD,   1);
        tbl[15] = mk(0, 10'h0, 0, 0, 0, 0, 0, 10'h0, 0, 0, 3, 2, ADD,   1);
        tbl[16] = mk(0, 10'h0, 0, 0, 0, 0, 0, 10'h0, 0, 0, 0, 3, ADD,   1);
        tbl[17] = mk(0, 10'h0, 0, 0, 0, 0, 0, 10'h0, 0, 0, 0, 0, 10'h0, 0);

        rstn = 1'b0;
        drive(0, 10'h0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("reset_stall",  32'(stall),     32'h0);
        chk("reset_ex",     32'({ex_ctrl, ex_rd, ex_valid}),    32'h0);
        chk("reset_mem",    32'({mem_ctrl, mem_rd, mem_valid}), 32'h0);
        chk("reset_wb",     32'({wb_ctrl, wb_rd, wb_valid}),    32'h0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].red);
            #2;
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ex_ctrl", i),  32'(ex_ctrl),  32'(tbl[i].ex_ctrl));
            chk($sformatf("vec%0d_ex_rd", i),    32'(ex_rd),    32'(tbl[i].ex_rd));
            chk($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'(tbl[i].ex_v));
            chk($sformatf("vec%0d_mem_rd", i),   32'(mem_rd),   32'(tbl[i].mem_rd));
            chk($sformatf("vec%0d_wb_rd", i),    32'(wb_rd),    32'(tbl[i].wb_rd));
            chk($sformatf("vec%0d_wb_ctrl", i),  32'(wb_ctrl),  32'(tbl[i].wb_ctrl));
            chk($sformatf("vec%0d_wb_valid", i), 32'(wb_valid), 32'(tbl[i].wb_v));
        end

        // Fill all stages, raise a load-use stall, then reset asynchronously mid-cycle.
        @(negedge clk); drive(1, ADD, 0, 0, 1, 0);
        @(negedge clk); drive(1, ADD, 0, 0, 2, 0);
        @(negedge clk); drive(1, LW,  0, 0, 5, 0);
        @(negedge clk); drive(1, ADD, 5, 0, 6, 0);
        #2;
        chk("pre_reset_stall", 32'(stall), 32'h1);
        chk("pre_reset_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'h7);
        #1 rstn = 1'b0;
        #1;
        chk("async_reset_stall", 32'(stall), 32'h0);
        chk("async_reset_ex",  32'({ex_ctrl, ex_rd, ex_valid}),    32'h0);
        chk("async_reset_mem", 32'({mem_ctrl, mem_rd, mem_valid}), 32'h0);
        chk("async_reset_wb",  32'({wb_ctrl, wb_rd, wb_valid}),    32'h0);
        @(negedge clk);
        drive(0, 10'h0, 0, 0, 0, 0);
        rstn = 1'b1;

        for (int s = 0; s < 3; s++) pipe.push_back('{v: 1'b0, ctrl: 10'h0, rd: 5'h0});
        begin
            logic       hold, exp_stall, hz, v, red;
            logic [9:0] c;
            logic [4:0] r1, r2, rd;
            logic [31:0] rnd;
            stg_t       nx;
            hold = 1'b0;
            v = 0; c = '0; r1 = '0; r2 = '0; rd = '0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                if (!hold) begin
                    rnd = $urandom;
                    v  = (rnd[31:28] != 4'd0);
                    c  = rnd[9:0];
                    r1 = 5'($urandom_range(0, 3));
                    r2 = 5'($urandom_range(0, 3));
                    rd = 5'($urandom_range(0, 3));
                end
                red = ($urandom_range(0, 9) == 0);
                drive(v, c, r1, r2, rd, red);
                hz = v && ((pipe[0].v && pipe[0].ctrl[6] && reads_reg(c, r1, r2, pipe[0].rd)) ||
                           (pipe[0].v && pipe[0].ctrl[0] && reads_reg(c, r1, r2, pipe[0].rd)) ||
                           (pipe[1].v && pipe[1].ctrl[0] && reads_reg(c, r1, r2, pipe[1].rd)));
                exp_stall = hz && !red;
                #2;
                chk("rand_stall", 32'(stall), 32'(exp_stall));
                if (red || exp_stall || !v) nx = '{v: 1'b0, ctrl: 10'h0, rd: 5'h0};
                else                        nx = '{v: 1'b1, ctrl: c, rd: rd};
                pipe.push_front(nx);
                void'(pipe.pop_back());
                @(posedge clk);
                #1;
                chk("rand_ex",  32'({ex_ctrl, ex_rd, ex_valid}),
                    32'({pipe[0].ctrl, pipe[0].rd, pipe[0].v}));
                chk("rand_mem", 32'({mem_ctrl, mem_rd, mem_valid}),
                    32'({pipe[1].ctrl, pipe[1].rd, pipe[1].v}));
                chk("rand_wb",  32'({wb_ctrl, wb_rd, wb_valid}),
                    32'({pipe[2].ctrl, pipe[2].rd, pipe[2].v}));
                hold = exp_stall;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
